// File: rtl/player_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : player_ctrl_if
// Description : Control bus from the game controller to the player car block:
//               one-cycle move pulses and the car recentre reset.
// Revision    : 1.0 - initial release
// ============================================================================
interface player_ctrl_if;
    logic left;     // one-cycle move-left pulse
    logic right;    // one-cycle move-right pulse
    logic car_rst;  // active-high recentre of the car

    modport master (output left, right, car_rst);
    modport slave  (input  left, right, car_rst);
endinterface
`default_nettype wire

// File: rtl/player_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_ctrl
// Description : Game-level controller for the player car. Synchronises the
//               push-buttons, paces car moves to video frames, and runs the
//               idle / run / crash / game-over sequence with a lives counter.
// Revision    : 1.0 - initial release
// ============================================================================
module player_ctrl #(
    parameter int STEP_DIV     = 4,   // frame ticks per car step (1..16)
    parameter int CRASH_FRAMES = 60,  // frame ticks of crash spin-out (1..255)
    parameter int LIVES        = 3    // lives loaded at game start (1..3)
) (
    input  logic               clk,
    input  logic               reset,        // synchronous, active-low
    input  logic               frame_tick,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_start,
    input  logic               collision,
    player_ctrl_if.master      player,
    output logic [1:0]         state,
    output logic [1:0]         lives,
    output logic               crash_active,
    output logic               game_over
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] c_step_last  = 4'(STEP_DIV - 1);
    localparam logic [7:0] c_crash_last = 8'(CRASH_FRAMES - 1);
    localparam logic [1:0] c_lives_init = 2'(LIVES);

    // Synchroniser stages; r_start_prev lets us detect the start edge.
    logic   r_left_meta, r_left_sync;
    logic   r_right_meta, r_right_sync;
    logic   r_start_meta, r_start_sync, r_start_prev;
    logic   w_start_pulse;

    // Architectural state and registered outputs.
    state_t     r_state;
    logic [1:0] r_lives;
    logic [3:0] r_step_cnt;
    logic [7:0] r_crash_cnt;
    logic       r_left, r_right, r_car_rst;
    logic       r_crash_active, r_game_over;

    // Next-state values.
    state_t     w_state_nxt;
    logic [1:0] w_lives_nxt;
    logic [3:0] w_step_nxt;
    logic [7:0] w_crash_nxt;
    logic       w_left_nxt, w_right_nxt, w_car_rst_nxt;

    // Two-flop synchronisers for the asynchronous button pins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_left_meta  <= 1'b0;
            r_left_sync  <= 1'b0;
            r_right_meta <= 1'b0;
            r_right_sync <= 1'b0;
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_left_meta  <= btn_left;
            r_left_sync  <= r_left_meta;
            r_right_meta <= btn_right;
            r_right_sync <= r_right_meta;
            r_start_meta <= btn_start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
        end
    end

    // Left combinational so the FSM reacts three cycles after the pin edge.
    assign w_start_pulse = r_start_sync & ~r_start_prev;

    // Next-state, counter and output decode for the game FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_lives_nxt   = r_lives;
        w_step_nxt    = r_step_cnt;
        w_crash_nxt   = r_crash_cnt;
        w_left_nxt    = 1'b0;
        w_right_nxt   = 1'b0;
        w_car_rst_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_car_rst_nxt = 1'b1;
                if (w_start_pulse) begin
                    w_state_nxt   = ST_RUN;
                    w_lives_nxt   = c_lives_init;
                    w_step_nxt    = 4'd0;
                    w_car_rst_nxt = 1'b0;
                end
            end

            ST_RUN: begin
                // Collision wins over a step landing in the same cycle.
                if (collision) begin
                    w_state_nxt = ST_CRASH;
                    w_lives_nxt = r_lives - 2'd1;
                    w_crash_nxt = 8'd0;
                end else if (frame_tick) begin
                    if (r_step_cnt == c_step_last) begin
                        w_step_nxt  = 4'd0;
                        // Both or neither button pressed: no move.
                        w_left_nxt  = r_left_sync & ~r_right_sync;
                        w_right_nxt = r_right_sync & ~r_left_sync;
                    end else begin
                        w_step_nxt = r_step_cnt + 4'd1;
                    end
                end
            end

            ST_CRASH: begin
                if (frame_tick) begin
                    if (r_crash_cnt == c_crash_last) begin
                        if (r_lives == 2'd0) begin
                            w_state_nxt = ST_OVER;
                        end else begin
                            w_state_nxt   = ST_RUN;
                            w_car_rst_nxt = 1'b1;
                            w_step_nxt    = 4'd0;
                        end
                    end else begin
                        w_crash_nxt = r_crash_cnt + 8'd1;
                    end
                end
            end

            ST_OVER: begin
                // Car is left at its crash position until the next start.
                if (w_start_pulse) begin
                    w_state_nxt   = ST_IDLE;
                    w_car_rst_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_car_rst_nxt = 1'b1;
            end
        endcase
    end

    // State register and registered outputs; reset cancels any pending pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_lives        <= 2'd0;
            r_step_cnt     <= 4'd0;
            r_crash_cnt    <= 8'd0;
            r_left         <= 1'b0;
            r_right        <= 1'b0;
            r_car_rst      <= 1'b1;
            r_crash_active <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_lives        <= w_lives_nxt;
            r_step_cnt     <= w_step_nxt;
            r_crash_cnt    <= w_crash_nxt;
            r_left         <= w_left_nxt;
            r_right        <= w_right_nxt;
            r_car_rst      <= w_car_rst_nxt;
            r_crash_active <= (w_state_nxt == ST_CRASH);
            r_game_over    <= (w_state_nxt == ST_OVER);
        end
    end

    assign player.left    = r_left;
    assign player.right   = r_right;
    assign player.car_rst = r_car_rst;
    assign state          = r_state;
    assign lives          = r_lives;
    assign crash_active   = r_crash_active;
    assign game_over      = r_game_over;

endmodule
`default_nettype wire

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Sequences the player car datapath (one-pixel-per-cycle left/right stepper, car_x reset to 120).
- Converts raw push-buttons into single-cycle, frame-paced move pulses.
- Runs the game-level FSM: idle, running, crash spin-out, game over. Owns the lives counter and the car respawn pulse.
- Sits between the button pins / collision detector and the player block.

Parameters:
- STEP_DIV, 4, frame_ticks per car move step (1..16)
- CRASH_FRAMES, 60, frame_ticks spent in crash spin-out (1..255)
- LIVES, 3, lives loaded at game start (1..3)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- frame_tick  input  1  one-cycle pulse once per video frame
- btn_left  input  1  raw left button, asynchronous
- btn_right  input  1  raw right button, asynchronous
- btn_start  input  1  raw start button, asynchronous
- collision  input  1  car overlaps obstacle/track edge, synchronous to clk
- left  output  1  one-cycle move-left pulse to player
- right  output  1  one-cycle move-right pulse to player
- car_rst  output  1  active-high reset to player (recentres car)
- state  output  2  0=IDLE, 1=RUN, 2=CRASH, 3=OVER
- lives  output  2  remaining lives
- crash_active  output  1  high while in CRASH
- game_over  output  1  high while in OVER

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, lives=0, left=right=0, car_rst=1, step and crash counters=0, synchronizers=0.
- Input sync: btn_left, btn_right and btn_start each pass through a 2-flop synchronizer.
- start_pulse: rising edge of the synchronized btn_start. It arrives 3 cycles after the pin edge.
- All outputs are registered.
- IDLE:
  - car_rst=1 continuously; left=right=0.
  - On start_pulse: lives<=LIVES, step_cnt<=0, go to RUN. car_rst drops the same edge.
- RUN, step pacing:
  - Each frame_tick increments step_cnt.
  - When frame_tick arrives with step_cnt==STEP_DIV-1: step_cnt<=0 and a move pulse issues on the next cycle, exactly 1 cycle wide.
  - Synchronized left only -> left=1. Right only -> right=1. Both or neither -> no pulse.
  - left and right are never high together.
- RUN, collision:
  - collision==1 -> go to CRASH, lives<=lives-1, crash_cnt<=0.
  - Collision has priority over a same-cycle step: no move pulse issues.
- CRASH:
  - crash_active=1; left=right=0; buttons ignored; crash_cnt increments on each frame_tick.
  - When frame_tick arrives with crash_cnt==CRASH_FRAMES-1:
    - lives==0 -> go to OVER.
    - Otherwise -> car_rst=1 for exactly one cycle, step_cnt<=0, return to RUN.
  - collision while in CRASH is ignored and lives is not decremented again.
- OVER:
  - game_over=1; left=right=0; car_rst=0, so the car stays at its crash position.
  - start_pulse -> go to IDLE.
- Width rules:
  - lives never wraps below 0: decrement only happens from RUN, and RUN is unreachable with lives==0.
  - step_cnt is 4 bits; crash_cnt is 8 bits.
- Edge cases:
  - frame_tick is ignored in IDLE and OVER.
  - start_pulse is ignored in RUN and CRASH.
  - A reset asserted mid-state returns the block to IDLE on that edge; any pending move pulse is cancelled.

Test Plan:
- Reset and start: reset=0 for 2 cycles, then 1 -> state=0, car_rst=1, lives=0. Pulse btn_start -> state=1 and lives=3 three cycles after the pin edge, car_rst=0 from that edge.
- Move pacing: RUN, btn_right held, 8 frame_ticks -> exactly 2 right pulses, each 1 cycle wide, each 1 cycle after the 4th and 8th frame_tick; left stays 0.
- Both buttons: RUN, btn_left=btn_right=1, 12 frame_ticks -> no left or right pulse at all.
- Collision priority: collision asserted in the same cycle as the 4th frame_tick -> no move pulse, state=2, lives 3->2, crash_active=1.
- Crash and respawn: in CRASH, 60 frame_ticks -> one-cycle car_rst, state=1. A collision during CRASH leaves lives unchanged.
- Game over: three crashes -> after the 3rd spin-out state=3, game_over=1, lives=0. btn_start -> state=0. Reset asserted mid-CRASH -> IDLE next edge, lives=0.
